// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two dmem requesters, the arbiter and the dmem port.
// slave is the arbiter's view; master is the environment (requesters + dmem).
interface dmem_port_arbiter_if;
    logic        rq0_req;
    logic        rq0_we;
    logic [1:0]  rq0_size;
    logic [31:0] rq0_addr;
    logic [31:0] rq0_wdata;
    logic        rq0_ack;

    logic        rq1_req;
    logic        rq1_we;
    logic [1:0]  rq1_size;
    logic [31:0] rq1_addr;
    logic [31:0] rq1_wdata;
    logic        rq1_ack;

    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_lwhb;
    logic [1:0]  mem_swhb;
    logic [31:0] mem_rdata;

    modport slave (
        input  rq0_req, rq0_we, rq0_size, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_we, rq1_size, rq1_addr, rq1_wdata,
        input  mem_rdata,
        output rq0_ack, rq1_ack, rsp_rdata, rsp_err, busy,
        output mem_write, mem_addr, mem_wdata, mem_lwhb, mem_swhb
    );

    modport master (
        output rq0_req, rq0_we, rq0_size, rq0_addr, rq0_wdata,
        output rq1_req, rq1_we, rq1_size, rq1_addr, rq1_wdata,
        output mem_rdata,
        input  rq0_ack, rq1_ack, rsp_rdata, rsp_err, busy,
        input  mem_write, mem_addr, mem_wdata, mem_lwhb, mem_swhb
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the shared dmem port.
// state  | meaning
// IDLE   | waiting for a request; picks winner and latches its fields
// ACCESS | mem_* driven for exactly one cycle; response captured at end
// RESP   | one-cycle ack to the granted requester
module dmem_port_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rstn,
    dmem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        g_id;
    logic        g_we;
    logic        g_err;
    logic [1:0]  g_size;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;

    logic        pick1;
    logic        w_we;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        pick1   = bus.rq1_req & (~bus.rq0_req | ~last_grant);
        w_we    = pick1 ? bus.rq1_we    : bus.rq0_we;
        w_size  = pick1 ? bus.rq1_size  : bus.rq0_size;
        w_addr  = pick1 ? bus.rq1_addr  : bus.rq0_addr;
        w_wdata = pick1 ? bus.rq1_wdata : bus.rq0_wdata;
        w_err   = (w_size == 2'b11)
                | ((w_size == 2'b01) & w_addr[0])
                | ((w_size == 2'b00) & (w_addr[1:0] != 2'b00))
                | ((w_addr >> ADDR_W) != 32'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            g_id          <= 1'b0;
            g_we          <= 1'b0;
            g_err         <= 1'b0;
            g_size        <= 2'b00;
            g_addr        <= 32'd0;
            g_wdata       <= 32'd0;
            bus.rq0_ack   <= 1'b0;
            bus.rq1_ack   <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_lwhb  <= 2'b00;
            bus.mem_swhb  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.rq0_ack <= 1'b0;
                    bus.rq1_ack <= 1'b0;
                    if (bus.rq0_req | bus.rq1_req) begin
                        g_id          <= pick1;
                        g_we          <= w_we;
                        g_err         <= w_err;
                        g_size        <= w_size;
                        g_addr        <= w_addr;
                        g_wdata       <= w_wdata;
                        // dmem decodes writes combinationally, so its inputs
                        // are registered here and live only during ACCESS.
                        bus.mem_addr  <= w_addr;
                        bus.mem_wdata <= w_wdata;
                        bus.mem_write <= w_we & ~w_err;
                        bus.mem_lwhb  <= (!w_we && !w_err) ? w_size : 2'b00;
                        bus.mem_swhb  <= (w_we && !w_err) ? (w_size + 2'd1) : 2'b00;
                        bus.busy      <= 1'b1;
                        state         <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    bus.rsp_rdata <= (!g_we && !g_err) ? bus.mem_rdata : 32'd0;
                    bus.rsp_err   <= g_err;
                    bus.mem_write <= 1'b0;
                    bus.mem_addr  <= 32'd0;
                    bus.mem_wdata <= 32'd0;
                    bus.mem_lwhb  <= 2'b00;
                    bus.mem_swhb  <= 2'b00;
                    bus.rq0_ack   <= ~g_id;
                    bus.rq1_ack   <= g_id;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    bus.rq0_ack <= 1'b0;
                    bus.rq1_ack <= 1'b0;
                    last_grant  <= g_id;
                    bus.busy    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    bus.rq0_ack   <= 1'b0;
                    bus.rq1_ack   <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.mem_write <= 1'b0;
                    bus.mem_lwhb  <= 2'b00;
                    bus.mem_swhb  <= 2'b00;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random single-requester
// traffic, checked against a byte-array memory model and address rules.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic mem_clr = 1'b1;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [1:0] last_swhb = 2'b00;

    logic [7:0] dmem [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic [9:0] rd_a;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.ADDR_W(10)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // dmem stand-in: combinational sign-extending read, clocked write.
    always_comb begin
        rd_a = bus.mem_addr[9:0];
        case (bus.mem_lwhb)
            2'b01:   bus.mem_rdata = {{16{dmem[rd_a + 10'd1][7]}}, dmem[rd_a + 10'd1], dmem[rd_a]};
            2'b10:   bus.mem_rdata = {{24{dmem[rd_a][7]}}, dmem[rd_a]};
            default: bus.mem_rdata = {dmem[rd_a + 10'd3], dmem[rd_a + 10'd2], dmem[rd_a + 10'd1], dmem[rd_a]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
        end else if (bus.mem_write === 1'b1) begin
            case (bus.mem_swhb)
                2'b01: begin
                    dmem[bus.mem_addr[9:0]]         <= bus.mem_wdata[7:0];
                    dmem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
                    dmem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_wdata[23:16];
                    dmem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_wdata[31:24];
                end
                2'b10: begin
                    dmem[bus.mem_addr[9:0]]         <= bus.mem_wdata[7:0];
                    dmem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
                end
                2'b11: dmem[bus.mem_addr[9:0]] <= bus.mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_swhb <= bus.mem_swhb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr);
        int a;
        logic [31:0] v;
        a = int'(addr % 1024);
        v = 32'(ref_mem[(a + 3) % 1024]) * 32'h0100_0000 + 32'(ref_mem[(a + 2) % 1024]) * 32'h0001_0000
          + 32'(ref_mem[(a + 1) % 1024]) * 32'h0000_0100 + 32'(ref_mem[a]);
        if (size == 2'd1) v = (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
        if (size == 2'd2) v = (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        for (int k = 0; k < n; k++) ref_mem[(int'(addr % 1024) + k) % 1024] = 8'((data >> (8 * k)) % 256);
    endtask

    task automatic drive_req(input int id, input logic req, input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            bus.rq0_req = req; bus.rq0_we = we; bus.rq0_size = size;
            bus.rq0_addr = addr; bus.rq0_wdata = wdata;
        end else begin
            bus.rq1_req = req; bus.rq1_we = we; bus.rq1_size = size;
            bus.rq1_addr = addr; bus.rq1_wdata = wdata;
        end
    endtask

    task automatic do_access(input int id, input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        logic exp_err;
        logic [31:0] exp_rd;
        int wr0, cyc;
        logic a0, a1;
        exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
               || (size == 2'd0 && addr % 4 != 0) || (addr > 32'h3FF);
        exp_rd  = (!we && !exp_err) ? ref_load(size, addr) : 32'd0;
        @(negedge clk);
        drive_req(id, 1'b1, we, size, addr, wdata);
        wr0 = wr_cnt;
        cyc = 0; a0 = 1'b0; a1 = 1'b0;
        while (cyc < 20 && !(a0 | a1)) begin
            @(posedge clk); #1;
            cyc++;
            a0 = bus.rq0_ack; a1 = bus.rq1_ack;
        end
        if (!(a0 | a1)) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc, 2);
            chk("ack_id", {30'd0, a1, a0}, (id == 0) ? 32'd1 : 32'd2);
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
            chk("rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("busy_resp", {31'd0, bus.busy}, 32'd1);
        end
        @(negedge clk);
        drive_req(id, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("wr_pulses", wr_cnt - wr0, (we && !exp_err) ? 32'd1 : 32'd0);
        if (we && !exp_err) begin
            chk("swhb", {30'd0, last_swhb}, 32'(size) + 32'd1);
            ref_store(size, addr, wdata);
        end
    endtask

    initial begin
        int acks, cyc, last_cyc, quiet;
        logic [1:0] rsz;
        logic [31:0] raddr;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_acks", {30'd0, bus.rq1_ack, bus.rq0_ack}, 32'd0);
        chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("rst_mem_codes", {28'd0, bus.mem_lwhb, bus.mem_swhb}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rsp", {bus.rsp_rdata[30:0], bus.rsp_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        do_access(0, 1'b1, 2'd0, 32'h010, 32'hDEADBEEF);
        do_access(0, 1'b0, 2'd0, 32'h010, 32'd0);

        do_access(1, 1'b1, 2'd2, 32'h021, 32'h0000_0080);
        do_access(1, 1'b0, 2'd2, 32'h021, 32'd0);
        do_access(1, 1'b1, 2'd1, 32'h022, 32'h0000_1234);
        do_access(1, 1'b0, 2'd1, 32'h022, 32'd0);

        do_access(0, 1'b1, 2'd0, 32'h003, 32'h1111_2222);
        do_access(0, 1'b0, 2'd1, 32'h005, 32'd0);
        do_access(1, 1'b1, 2'd3, 32'h030, 32'h5555_AAAA);
        do_access(0, 1'b0, 2'd0, 32'h400, 32'd0);
        do_access(1, 1'b1, 2'd2, 32'h8000_0004, 32'h77);

        // Contention from a fresh reset: requester 0 takes the first tie.
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        drive_req(0, 1'b1, 1'b0, 2'd0, 32'h010, 32'd0);
        drive_req(1, 1'b1, 1'b0, 2'd0, 32'h020, 32'd0);
        acks = 0; cyc = 0; last_cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rq0_ack | bus.rq1_ack) begin
                chk("cont_ack_excl", {31'd0, bus.rq0_ack & bus.rq1_ack}, 32'd0);
                chk("cont_order", {31'd0, bus.rq1_ack}, acks % 2);
                chk("cont_rdata", bus.rsp_rdata, ref_load(2'd0, (acks % 2 == 0) ? 32'h010 : 32'h020));
                if (acks == 0) chk("cont_first_lat", cyc, 2);
                else           chk("cont_gap", cyc - last_cyc, 3);
                last_cyc = cyc;
                acks++;
            end
        end
        if (acks < 4) chk("cont_timeout", acks, 4);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Reset during a store's ACCESS cycle.
        drive_req(0, 1'b1, 1'b1, 2'd0, 32'h040, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("abort_write_hi", {31'd0, bus.mem_write}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("abort_write_drop", {31'd0, bus.mem_write}, 32'd0);
        chk("abort_swhb", {30'd0, bus.mem_swhb}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        drive_req(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.rq0_ack | bus.rq1_ack) quiet++;
        end
        chk("abort_no_ack", quiet, 0);
        @(negedge clk); rstn = 1'b1;
        do_access(0, 1'b0, 2'd0, 32'h040, 32'd0);
        do_access(0, 1'b1, 2'd0, 32'h040, 32'hCAFEF00D);
        do_access(1, 1'b0, 2'd0, 32'h040, 32'd0);

        for (int n = 0; n < 40; n++) begin
            rsz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            raddr = 32'($urandom_range(0, 63) + 256);
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd0) raddr = raddr - raddr % 4;
                if (rsz == 2'd1) raddr = raddr - raddr % 2;
            end
            if ($urandom_range(0, 11) == 0) raddr = $urandom;
            do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsz, raddr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
